pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It is the driving side of the pipeline-register control interface. It generates the `enable` and `reset` inputs of every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable from three sources: load-use hazards, taken branches and multicycle data-memory accesses. A small FSM tracks memory waits, enforces a timeout and keeps saturating stall/flush statistics.

## Interface
Parameters:
- `REG_W`, 4, register-address width
- `MAX_MEM_WAIT`, 15, maximum consecutive memory-wait cycles before timeout (≥1)
- `CNT_W`, 16, width of statistics counters

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `id_rs1`, `id_rs2`  in  REG_W  source registers of instruction in ID
- `id_rs1_used`, `id_rs2_used`  in  1  corresponding source actually read
- `ex_rd`  in  REG_W  destination of instruction in EX
- `ex_memread`  in  1  instruction in EX is a load
- `ex_branch_taken`  in  1  branch in EX resolved taken
- `mem_req`  in  1  instruction in MEM is accessing data memory
- `mem_ready`  in  1  data memory completes access this cycle
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1  register enables
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1  register resets (flush has priority over enable at the register)
- `mem_timeout`  out  1  sticky timeout error
- `stall_count`  out  CNT_W  cycles with `pc_en`=0 due to hazard or memory wait
- `flush_count`  out  CNT_W  branch flushes performed

## Operation
- FSM states: RUN, MEMWAIT, ERROR. Reset state: RUN.
- Control outputs are combinational in (state, inputs). FSM, wait counter and statistics are registered.
- While `reset`=1: all `*_flush`=1, all `*_en`=0, `mem_timeout`=0. Next state is RUN; wait counter and both statistics counters are cleared to 0.
- Priority, highest first: reset > ERROR > memory stall > branch flush > load-use > normal.
- Memory stall (`mem_req`=1 & `mem_ready`=0, in RUN or MEMWAIT):
  - `pc_en`, `ifid_en`, `idex_en`, `exmem_en` = 0
  - `memwb_flush`=1 (bubble into WB)
  - a pending branch or load-use is held, not acted on
- Branch flush (`ex_branch_taken`=1, no memory stall):
  - all enables = 1 (PC loads target)
  - `ifid_flush`=1, `idex_flush`=1
  - squashes any simultaneous load-use
- Load-use: `ex_memread`=1 & ((`id_rs1_used` & `id_rs1`==`ex_rd`) | (`id_rs2_used` & `id_rs2`==`ex_rd`)).
  - `pc_en`=0, `ifid_en`=0, `idex_flush`=1, others enabled
  - exactly one bubble per hazard, because the load leaves EX next cycle
  - no register index is exempt from comparison
- Normal: all enables 1, all flushes 0.
- Transitions:
  - RUN→MEMWAIT on a memory-stall cycle.
  - MEMWAIT→RUN on the cycle `mem_ready`=1 or `mem_req`=0. That cycle's outputs are normal/branch/load-use per priority.
  - Wait counter increments on each stall cycle and clears on leaving MEMWAIT. If a stall cycle occurs with counter == MAX_MEM_WAIT−1, next state is ERROR.
- ERROR: all enables 0, all flushes 0, `mem_timeout`=1. Exit only by reset.
- Statistics counters saturate at all-ones and never wrap.
  - `stall_count` increments on each memory-stall or load-use cycle (not during reset or ERROR).
  - `flush_count` increments on each branch-flush cycle.

## Timing
- Hazard-to-control latency is 0 cycles (same-cycle combinational). State and counters update at the next posedge.
- A memory access finishing on its first cycle (`mem_ready`=1) causes no stall and no state change.
- With `mem_ready` held low: stall cycles 1..MAX_MEM_WAIT, then ERROR from cycle MAX_MEM_WAIT+1.
- `mem_ready` on the exact cycle the counter reaches MAX_MEM_WAIT−1 means no stall that cycle, so ERROR is not entered.
- Reset asserted mid-MEMWAIT or in ERROR takes effect the same cycle on outputs, and on state at the next posedge.
- Statistics counters are valid one cycle after the counted event.

## Test plan
- Load-use: `ex_memread`=1, `ex_rd`=3, `id_rs2`=3, `id_rs2_used`=1 for one cycle → `pc_en`=0, `ifid_en`=0, `idex_flush`=1 for that cycle; `stall_count` goes 0→1.
- Unused-operand match: same as above but `id_rs2_used`=0 and `id_rs1`=5 → no stall, all enables 1.
- Branch plus load-use in the same cycle → `ifid_flush`=`idex_flush`=1, `pc_en`=1; `flush_count`=1, `stall_count` unchanged.
- Memory wait: `mem_req`=1, `mem_ready`=0 for 3 cycles, then 1 → 3 cycles with `exmem_en`=0 and `memwb_flush`=1; state returns to RUN; `stall_count`=3.
- Timeout: MAX_MEM_WAIT=15, `mem_ready` held 0 → `mem_timeout`=1 from cycle 16 with all enables 0. `mem_timeout` stays 1 with `mem_ready`=1 applied, and clears only after `reset`.
- Saturation: CNT_W=4, 20 load-use cycles → `stall_count`=15. Branch held during a memory stall → no flush until `mem_ready`=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Hazard inputs and pipeline-register control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memread;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_memread,
               ex_branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               mem_timeout, stall_count, flush_count
    );

    modport slave (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_memread,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               mem_timeout, stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush controller for the five-stage pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 16
) (
    input  wire                    clk,
    input  wire                    reset,
    pipeline_hazard_ctrl_if.master bus
);

    localparam int WAIT_W = (MAX_MEM_WAIT < 2) ? 1 : $clog2(MAX_MEM_WAIT + 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MAX_MEM_WAIT - 1);
    localparam logic [WAIT_W-1:0] c_wait_one  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERROR   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_load_use;
    logic w_mem_stall;
    logic w_cnt_stall;
    logic w_cnt_flush;

    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_flush;
    logic w_memwb_flush;
    logic w_timeout;

    assign w_load_use = bus.ex_memread &
                        ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
                         (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd)));

    assign w_mem_stall = bus.mem_req & ~bus.mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        w_cnt_stall   = 1'b0;
        w_cnt_flush   = 1'b0;
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;
        w_timeout     = 1'b0;

        if (reset) begin
            w_state_nxt   = ST_RUN;
            w_wait_nxt    = '0;
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_memwb_en    = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_memwb_flush = 1'b1;
        end else if (r_state == ST_ERROR) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_en  = 1'b0;
            w_exmem_en = 1'b0;
            w_memwb_en = 1'b0;
            w_timeout  = 1'b1;
        end else if (w_mem_stall) begin
            // Front of the pipe freezes; WB receives a bubble.
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_memwb_flush = 1'b1;
            w_cnt_stall   = 1'b1;
            w_wait_nxt    = r_wait + c_wait_one;
            w_state_nxt   = (r_wait == c_wait_last) ? ST_ERROR : ST_MEMWAIT;
        end else begin
            w_state_nxt = ST_RUN;
            w_wait_nxt  = '0;
            if (bus.ex_branch_taken) begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
                w_cnt_flush  = 1'b1;
            end else if (w_load_use) begin
                // One bubble suffices: the load leaves EX next cycle.
                w_pc_en      = 1'b0;
                w_ifid_en    = 1'b0;
                w_idex_flush = 1'b1;
                w_cnt_stall  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_cnt_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_cnt_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.idex_en     = w_idex_en;
    assign bus.exmem_en    = w_exmem_en;
    assign bus.memwb_en    = w_memwb_en;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_flush = w_exmem_flush;
    assign bus.memwb_flush = w_memwb_flush;
    assign bus.mem_timeout = w_timeout;
    assign bus.stall_count = r_stall_cnt;
    assign bus.flush_count = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed and randomized checks against a cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int REG_W        = 4;
    localparam int MAX_MEM_WAIT = 15;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .REG_W        (REG_W),
        .MAX_MEM_WAIT (MAX_MEM_WAIT),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: consecutive stall count, sticky error, event totals.
    int m_waits   = 0;
    bit m_err     = 1'b0;
    int m_stalls  = 0;
    int m_flushes = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input int rs1, input bit u1, input int rs2,
                         input bit u2, input int rd, input bit ld, input bit br,
                         input bit req, input bit rdy);
        reset               = rst;
        bus.id_rs1          = REG_W'(rs1);
        bus.id_rs1_used     = u1;
        bus.id_rs2          = REG_W'(rs2);
        bus.id_rs2_used     = u2;
        bus.ex_rd           = REG_W'(rd);
        bus.ex_memread      = ld;
        bus.ex_branch_taken = br;
        bus.mem_req         = req;
        bus.mem_ready       = rdy;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic tick(input string tag);
        int         cls;
        bit         lu;
        logic [9:0] exp_v;
        logic [9:0] got_v;
        logic [9:0] mask;
        @(negedge clk);
        lu = bus.ex_memread &&
             ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
        if (reset)                               cls = 0;
        else if (m_err)                          cls = 1;
        else if (bus.mem_req && !bus.mem_ready)  cls = 2;
        else if (bus.ex_branch_taken)            cls = 3;
        else if (lu)                             cls = 4;
        else                                     cls = 5;
        // {pc, ifid, idex, exmem, memwb enables, four flushes, timeout}
        mask = 10'h3FF;
        case (cls)
            0:       exp_v = 10'b00000_1111_0;
            1:       exp_v = 10'b00000_0000_1;
            2: begin exp_v = 10'b00001_0001_0; mask = 10'b11110_1111_1; end
            3:       exp_v = 10'b11111_1100_0;
            4:       exp_v = 10'b00111_0100_0;
            default: exp_v = 10'b11111_0000_0;
        endcase
        got_v = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                 bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush,
                 bus.mem_timeout};
        chk({tag, ".ctrl"}, 32'(got_v & mask), 32'(exp_v & mask));
        chk({tag, ".stall_count"}, 32'(bus.stall_count), 32'(m_stalls));
        chk({tag, ".flush_count"}, 32'(bus.flush_count), 32'(m_flushes));
        @(posedge clk);
        case (cls)
            0: begin m_waits = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0; end
            1: ;
            2: begin
                m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
                m_waits++;
                if (m_waits >= MAX_MEM_WAIT) m_err = 1'b1;
            end
            3: begin
                m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
                m_waits = 0;
            end
            4: begin
                m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
                m_waits = 0;
            end
            default: m_waits = 0;
        endcase
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("reset");
        tick("reset");
        idle();
    endtask

    initial begin
        idle();
        do_reset();
        tick("idle");

        // Load-use via rs2, then a matching register that is not read.
        drive(0, 1, 1, 3, 1, 3, 1, 0, 0, 0); tick("loaduse");
        drive(0, 5, 1, 3, 0, 3, 1, 0, 0, 0); tick("unused_op");
        drive(0, 0, 1, 7, 0, 0, 1, 0, 0, 0); tick("rs1_zero");

        // Branch squashes a simultaneous load-use.
        drive(0, 3, 1, 0, 0, 3, 1, 1, 0, 0); tick("br_lu");
        idle(); tick("after_br");

        // Three-cycle memory wait, then completion with a first-cycle hit.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick("memwait");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick("memdone");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick("memhit");

        // Branch held across a stall is deferred until the access completes.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); tick("br_held");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); tick("br_release");
        idle(); tick("idle2");

        // Ready arrives exactly when one more stall would time out.
        for (int i = 0; i < MAX_MEM_WAIT - 1; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick("near_timeout");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick("ready_edge");
        idle(); tick("no_error");

        // Full timeout: sticky through ready, cleared only by reset.
        do_reset();
        for (int i = 0; i < MAX_MEM_WAIT + 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick("timeout");
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 2, 1, 0, 0, 2, 1, 1, 1, 1); tick("err_sticky");
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick("err_reset");
        idle(); tick("post_err");

        // Stall counter saturation.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 9, 1, 9, 1, 0, 0, 0); tick("saturate");
        end
        idle(); tick("sat_hold");

        // Randomized traffic; small register range makes matches common.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) < 2,
                  $urandom_range(3), $urandom_range(1),
                  $urandom_range(3), $urandom_range(1),
                  $urandom_range(3), $urandom_range(1),
                  $urandom_range(99) < 20,
                  $urandom_range(99) < 40,
                  $urandom_range(99) < 45);
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
